// File: rtl/switch_debouncer_pkg.sv
// Shared sizing helpers for the switch debouncer slice.
package switch_debouncer_pkg;

  localparam int EVENT_COUNT_W = 8;

  function automatic int count_max(input int clk_hz, input int debounce_ms);
    return clk_hz / 1000 * debounce_ms;
  endfunction

  // A counter needs at least one bit even when COUNT_MAX is tiny.
  function automatic int cnt_width(input int cmax);
    int w;
    w = $clog2(cmax);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// One switch bit: two-flop synchroniser, saturating stability counter,
// stable level register and one-cycle rise/fall strobes.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int COUNT_MAX = 4,
  parameter int CNT_W     = cnt_width(COUNT_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             stable_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      // Any agreement restarts qualification; only COUNT_MAX straight
      // disagreeing samples move the stable level.
      if (s2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= s2_reg;
        cnt_reg    <= '0;
        rise_reg   <= s2_reg;
        fall_reg   <= ~s2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw slide switches for the display stage.
// Define SWITCH_DEBOUNCER_EVENT_COUNT_EN to add the EVENT_COUNT output.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [0:WIDTH-1] SW_RAW,
  output logic [0:WIDTH-1] SW,
  output logic [0:WIDTH-1] SW_RISE,
  output logic [0:WIDTH-1] SW_FALL
`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
  ,
  output logic [EVENT_COUNT_W-1:0] EVENT_COUNT
`endif
);

  localparam int COUNT_MAX = count_max(CLK_HZ, DEBOUNCE_MS);
  localparam int CNT_W     = cnt_width(COUNT_MAX);

  if (COUNT_MAX < 2) begin : g_bad_count_max
    $error("switch_debouncer: COUNT_MAX must be at least 2");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    debounce_channel #(
      .COUNT_MAX(COUNT_MAX),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk   (CLOCK_50),
      .rst   (RESET),
      .raw   (SW_RAW[gi]),
      .stable(SW[gi]),
      .rise  (SW_RISE[gi]),
      .fall  (SW_FALL[gi])
    );
  end

`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
  logic [EVENT_COUNT_W-1:0] event_count_reg;
  logic [EVENT_COUNT_W-1:0] event_count_next;

  // Accumulator wraps modulo 2**EVENT_COUNT_W by construction.
  always_comb begin
    event_count_next = event_count_reg;
    for (int i = 0; i < WIDTH; i++) begin
      event_count_next = event_count_next + EVENT_COUNT_W'(SW_RISE[i] | SW_FALL[i]);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) event_count_reg <= '0;
    else       event_count_reg <= event_count_next;
  end

  assign EVENT_COUNT = event_count_reg;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (COUNT_MAX = 4, six channels).
module tb_switch_debouncer;

  localparam int W      = 6;
  localparam int CLK_HZ = 1000;
  localparam int DMS    = 4;
  localparam int CM     = CLK_HZ / 1000 * DMS;
  localparam int HIST   = CM + 2;

  logic         clk = 1'b0;
  logic         RESET;
  logic [0:W-1] SW_RAW;
  logic [0:W-1] SW;
  logic [0:W-1] SW_RISE;
  logic [0:W-1] SW_FALL;
`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
  logic [7:0]   EVENT_COUNT;
`endif

  switch_debouncer #(
    .WIDTH      (W),
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DMS)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (RESET),
    .SW_RAW  (SW_RAW),
    .SW      (SW),
    .SW_RISE (SW_RISE),
    .SW_FALL (SW_FALL)
`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
    ,
    .EVENT_COUNT(EVENT_COUNT)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rise_cnt [W];
  int fall_cnt [W];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [0:W-1] sw;
    logic [0:W-1] rise;
    logic [0:W-1] fall;
    logic [7:0]   ev;
  } exp_t;

  exp_t sbq[$];

  // Reference: a level is accepted once the last CM synchronised samples
  // (raw samples two edges old and earlier) all agree and differ from SW.
  logic [0:W-1] hist [HIST];
  logic [0:W-1] m_sw, m_rise, m_fall;
  logic [7:0]   m_ev;

  always @(posedge clk) begin
    exp_t e;
    bit   settled;
    if (RESET) begin
      for (int j = 0; j < HIST; j++) hist[j] = '0;
      m_sw = '0; m_rise = '0; m_fall = '0; m_ev = '0;
    end else begin
      m_ev = m_ev + 8'($countones(m_rise | m_fall));
      for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = SW_RAW;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        settled = 1'b1;
        for (int j = 2; j < HIST; j++)
          if (hist[j][i] != hist[2][i]) settled = 1'b0;
        if (settled && hist[2][i] != m_sw[i]) begin
          m_sw[i]   = hist[2][i];
          m_rise[i] = hist[2][i];
          m_fall[i] = ~hist[2][i];
        end
      end
    end
    e.sw = m_sw; e.rise = m_rise; e.fall = m_fall; e.ev = m_ev;
    sbq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < W; i++) begin
      if (SW_RISE[i]) rise_cnt[i]++;
      if (SW_FALL[i]) fall_cnt[i]++;
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_sw",   32'(SW),      32'(e.sw));
      chk("sb_rise", 32'(SW_RISE), 32'(e.rise));
      chk("sb_fall", 32'(SW_FALL), 32'(e.fall));
`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
      chk("sb_event_count", 32'(EVENT_COUNT), 32'(e.ev));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench just after a falling edge, n rising edges later.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
  endtask

  initial begin
    int r0, r2, f2, r1, f1, f3;
    logic [0:W-1] pat;
    for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
    RESET  = 1'b1;
    SW_RAW = '0;
    step(3);
    chk("reset_sw",   32'(SW),      32'd0);
    chk("reset_rise", 32'(SW_RISE), 32'd0);
    RESET = 1'b0;
    step(2);

    // Clean rise on channel 0
    r0 = rise_cnt[0];
    SW_RAW[0] = 1'b1;
    step(5);
    chk("rise_sw0_before", 32'(SW[0]), 32'd0);
    step(1);
    chk("rise_sw0_at",   32'(SW[0]), 32'd1);
    chk("rise_strobe0",  32'(SW_RISE[0]), 32'd1);
    chk("rise_others",   32'(SW[1:W-1]), 32'd0);
    step(1);
    chk("rise_strobe0_gone", 32'(SW_RISE[0]), 32'd0);
    chk("rise_count0", 32'(rise_cnt[0] - r0), 32'd1);

    // Glitch of 3 cycles on channel 2 is ignored
    r2 = rise_cnt[2]; f2 = fall_cnt[2];
    SW_RAW[2] = 1'b1; step(3); SW_RAW[2] = 1'b0; step(12);
    chk("glitch3_sw2",   32'(SW[2]), 32'd0);
    chk("glitch3_rises", 32'(rise_cnt[2] - r2), 32'd0);
    // 4-cycle pulse qualifies then falls back
    SW_RAW[2] = 1'b1; step(4); SW_RAW[2] = 1'b0; step(14);
    chk("pulse4_rises", 32'(rise_cnt[2] - r2), 32'd1);
    chk("pulse4_falls", 32'(fall_cnt[2] - f2), 32'd1);
    chk("pulse4_sw2",   32'(SW[2]), 32'd0);

    // Bounce on channel 1, then settle high
    r1 = rise_cnt[1]; f1 = fall_cnt[1];
    for (int t = 0; t < 6; t++) begin SW_RAW[1] = ~t[0]; step(2); end
    SW_RAW[1] = 1'b1;
    step(5);
    chk("bounce_sw1_before", 32'(SW[1]), 32'd0);
    step(1);
    chk("bounce_sw1_at", 32'(SW[1]), 32'd1);
    step(6);
    chk("bounce_rises", 32'(rise_cnt[1] - r1), 32'd1);
    chk("bounce_falls", 32'(fall_cnt[1] - f1), 32'd0);

    // Simultaneous pattern
    SW_RAW = '0; step(10);
    pat = 6'b101101;
    SW_RAW = pat;
    step(5);
    chk("simul_before", 32'(SW), 32'd0);
    step(1);
    chk("simul_sw",   32'(SW), 32'(pat));
    chk("simul_rise", 32'(SW_RISE), 32'(pat));
    step(1);
    chk("simul_rise_gone", 32'(SW_RISE), 32'd0);

    // Reset while channel 3 is counting toward a fall
    SW_RAW = 6'b000100; step(10);
    chk("pre_reset_sw3", 32'(SW[3]), 32'd1);
    SW_RAW[3] = 1'b0;
    step(4);
    f3 = fall_cnt[3];
    RESET = 1'b1;
    #1;
    chk("async_reset_sw",   32'(SW), 32'd0);
    chk("async_reset_fall", 32'(SW_FALL), 32'd0);
    SW_RAW[3] = 1'b1;
    step(2);
    RESET = 1'b0;
    step(5);
    chk("rel_sw3_before", 32'(SW[3]), 32'd0);
    step(1);
    chk("rel_sw3_at",   32'(SW[3]), 32'd1);
    chk("rel_rise3",    32'(SW_RISE[3]), 32'd1);
    chk("rel_no_fall3", 32'(fall_cnt[3] - f3), 32'd0);

`ifdef SWITCH_DEBOUNCER_EVENT_COUNT_EN
    SW_RAW = '0;
    do_reset();
    chk("ev_reset", 32'(EVENT_COUNT), 32'd0);
    SW_RAW = 6'b111000; step(7);
    chk("ev_three", 32'(EVENT_COUNT), 32'd3);
    SW_RAW = '0; step(7);
    chk("ev_six", 32'(EVENT_COUNT), 32'd6);
    do_reset();
    for (int t = 0; t < 42; t++) begin SW_RAW = ~SW_RAW; step(8); end
    SW_RAW = 6'b111100; step(8);
    chk("ev_wrap", 32'(EVENT_COUNT), 32'd0);
`endif

    // Randomised phase: mixture of short glitches and qualifying holds
    for (int t = 0; t < 300; t++) begin
      SW_RAW[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        RESET = 1'b1; step(1); RESET = 1'b0;
      end
      step($urandom_range(1, 8));
    end
    step(10);
    chk("sb_drained", 32'(sbq.size() <= 1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Front-end conditioning stage that sits between the raw board slide switches and the switch-to-LED/7-segment display stage.
- Each raw switch input is synchronised into the clock domain and debounced with its own saturating stability counter.
- The block produces a clean SW vector for the display stage, plus one-cycle rise and fall strobes per channel.

Parameters:
- WIDTH, 6: number of switch channels.
- CLK_HZ, 50000000: clock frequency in Hz.
- DEBOUNCE_MS, 10: required stable time in ms. COUNT_MAX = CLK_HZ/1000*DEBOUNCE_MS. COUNT_MAX must be at least 2; elaboration fails otherwise.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- SW_RAW  input  [0:WIDTH-1]  raw asynchronous switch levels (bit 0 = switch 0).
- SW  output  [0:WIDTH-1]  debounced stable levels, fed directly to the display stage.
- SW_RISE  output  [0:WIDTH-1]  one-cycle strobe when SW[i] changes 0->1.
- SW_FALL  output  [0:WIDTH-1]  one-cycle strobe when SW[i] changes 1->0.
- Interface decision: one clock, CLOCK_50; reset RESET is asynchronous and active-high.

Behaviour:
- Reset: while RESET=1, all synchroniser flops, counters, SW, SW_RISE and SW_FALL are 0, immediately and asynchronously. Deassertion is taken on a clock edge.
- Per channel i, evaluated every rising edge, in priority order:
  - Synchroniser: s1 <= SW_RAW[i]; s2 <= s1. Only s2 is used downstream.
  - If s2 == SW[i]: cnt <= 0.
  - Else if cnt == COUNT_MAX-1: SW[i] <= s2; cnt <= 0; SW_RISE[i] <= s2; SW_FALL[i] <= ~s2.
  - Else: cnt <= cnt+1.
  - SW_RISE[i] and SW_FALL[i] default to 0 on every edge without an update. Each strobe is high for exactly the cycle in which SW[i] first shows its new value.
- Counter: width $clog2(COUNT_MAX), unsigned. It never exceeds COUNT_MAX-1, so no wrap-around is possible.
- Acceptance rule: s2 must differ from SW[i] on COUNT_MAX consecutive edges.
  - A disagreement lasting COUNT_MAX-1 cycles is discarded and the counter clears.
  - Any return to agreement restarts the count from 0.
- Latency: SW_RAW stable from edge k (first sampled into s1) gives SW updated at edge k+COUNT_MAX+1. That is COUNT_MAX+2 edges including the sampling edge.
- Channels are fully independent. Any number may update on the same edge.
- SW_RISE[i] and SW_FALL[i] are never both high.
- Reset mid-count: the count is lost and SW returns to 0 even if it was 1. No strobe is emitted for that forced change. After release, a raw level of 1 is re-qualified with full latency.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_EVENT_COUNT_EN.
- Defined: adds output EVENT_COUNT [7:0].
  - Increments by the number of set bits in (SW_RISE | SW_FALL) on each edge, modulo 256 (wraps 255 -> 0).
  - Reset value 0.
  - The increment is combinational popcount into a registered accumulator.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package switch_debouncer_pkg:
  - function count_max(clk_hz, debounce_ms);
  - function cnt_width(count_max), returning $clog2 with a minimum of 1;
  - localparam EVENT_COUNT_W = 8.
- Sub-module debounce_channel: one bit, containing the synchroniser, counter, stable flop and both strobes. It takes parameters COUNT_MAX and CNT_W.
- switch_debouncer instantiates WIDTH copies in a generate loop and holds the optional event accumulator.

Test Plan:
All scenarios use CLK_HZ=1000 and DEBOUNCE_MS=4, so COUNT_MAX=4 and latency = 6 edges.
- Clean rise: after reset, SW_RAW[0]=1 held from edge k -> SW[0]=1 at edge k+5. SW_RISE[0]=1 for that single cycle only. Other channels stay 0.
- Glitch rejection: SW_RAW[2] high for exactly 3 cycles, then low -> SW[2] stays 0 and no strobes. With a 4-cycle high pulse instead -> SW[2] rises once, then falls after the low level qualifies. Exactly one RISE and one FALL.
- Bounce: SW_RAW[1] toggles every 2 cycles for 12 cycles, then settles at 1 -> exactly one SW_RISE[1], 6 edges after the settle edge. No FALL.
- Simultaneous: SW_RAW = 6'b101101 applied on one edge -> SW = 101101 six edges later. SW_RISE = 101101 for one cycle.
- Reset mid-operation: SW[3]=1 with the counter at 2 toward a fall; assert RESET asynchronously -> SW=0 with no clock edge and no strobes. Release with SW_RAW[3]=1 -> SW[3] rises with full 6-edge latency.
- With SWITCH_DEBOUNCER_EVENT_COUNT_EN: 3 simultaneous rises then 3 falls -> EVENT_COUNT reads 3 then 6. Drive 256 qualified edges -> EVENT_COUNT wraps to 0.
